// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  // Controller states: request outstanding, instruction held, halted on error.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

  // Size of one instruction word in bytes.
  localparam logic [31:0] INSN_BYTES = 32'd4;

  // Width of the request wait counter; wide enough for MAX_WAIT up to 255.
  localparam int unsigned WAIT_CTR_W = 8;

  // Sequential fetch address; wraps naturally modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INSN_BYTES;
  endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// Request wait counter: counts request cycles that ended without an ack and
// flags the cycle on which the MAX_WAIT-th such cycle is happening.
module fetch_wait_ctr
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_CTR_W-1:0] LAST_CNT = WAIT_CTR_W'(MAX_WAIT - 1);

  logic [WAIT_CTR_W-1:0] cnt_q;
  logic [WAIT_CTR_W-1:0] cnt_d;

  // Expired while the current no-ack cycle is the MAX_WAIT-th in a row.
  assign expired = en && (cnt_q == LAST_CNT);

  // Next count: clear wins, otherwise advance on each waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + WAIT_CTR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, holds the
// returned instruction for decode, handles redirects and request timeouts.
// Optional build macro FETCH_CTRL_MISALIGN_TRAP_EN: when defined, a redirect
// to a non word-aligned target halts the controller with misalign_err; when
// undefined, the low two target bits are cleared instead.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        fetch_err,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         imem_req_q, imem_req_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  inst_data_q, inst_data_d;
  logic         fetch_err_q, fetch_err_d;
  logic         misalign_err_q, misalign_err_d;

  logic         ctr_clr;
  logic         ctr_en;
  logic         ctr_expired;

  logic [31:0]  redir_pc;
  logic         redir_bad;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  // Count only cycles where a real request is outstanding and unanswered.
  assign ctr_en = (state_q == FETCH) && imem_req_q && !imem_ack;

  fetch_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign inst_valid   = inst_valid_q;
  assign inst_pc      = inst_pc_q;
  assign inst_data    = inst_data_q;
  assign fetch_err    = fetch_err_q;
  assign misalign_err = misalign_err_q;

  // Next-state and registered-output computation for the fetch FSM.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    imem_req_d     = imem_req_q;
    inst_valid_d   = inst_valid_q;
    inst_pc_d      = inst_pc_q;
    inst_data_d    = inst_data_q;
    fetch_err_d    = fetch_err_q;
    misalign_err_d = misalign_err_q;
    ctr_clr        = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redir_bad) begin
          // Misaligned redirect target halts the controller.
          state_d        = ERR;
          imem_req_d     = 1'b0;
          inst_valid_d   = 1'b0;
          pend_valid_d   = 1'b0;
          fetch_err_d    = 1'b1;
          misalign_err_d = 1'b1;
        end else if (!imem_req_q) begin
          // First cycle out of reset: nothing outstanding, so any ack is
          // stale and ignored; a redirect simply replaces the start address.
          imem_req_d = 1'b1;
          ctr_clr    = 1'b1;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end
        end else if (imem_ack) begin
          if (redirect_valid) begin
            // Response belongs to a squashed path; refetch at the new target.
            pc_d         = redir_pc;
            pend_valid_d = 1'b0;
            ctr_clr      = 1'b1;
          end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
            ctr_clr      = 1'b1;
          end else begin
            state_d      = HOLD;
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            inst_data_d  = imem_rdata;
          end
        end else if (ctr_expired) begin
          state_d      = ERR;
          imem_req_d   = 1'b0;
          inst_valid_d = 1'b0;
          pend_valid_d = 1'b0;
          fetch_err_d  = 1'b1;
        end else if (redirect_valid) begin
          // Address must stay stable while requesting; remember the target.
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_pc;
        end
      end

      HOLD: begin
        if (redir_bad) begin
          state_d        = ERR;
          inst_valid_d   = 1'b0;
          fetch_err_d    = 1'b1;
          misalign_err_d = 1'b1;
        end else if (redirect_valid) begin
          // Redirect beats a simultaneous accept: drop the held word.
          state_d      = FETCH;
          pc_d         = redir_pc;
          imem_req_d   = 1'b1;
          inst_valid_d = 1'b0;
          ctr_clr      = 1'b1;
        end else if (inst_ready) begin
          state_d      = FETCH;
          pc_d         = next_pc(pc_q);
          imem_req_d   = 1'b1;
          inst_valid_d = 1'b0;
          ctr_clr      = 1'b1;
        end
      end

      ERR: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
        fetch_err_d  = 1'b1;
      end

      default: begin
        state_d     = ERR;
        imem_req_d  = 1'b0;
        fetch_err_d = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      pend_valid_q   <= 1'b0;
      pend_pc_q      <= '0;
      imem_req_q     <= 1'b0;
      inst_valid_q   <= 1'b0;
      inst_pc_q      <= '0;
      inst_data_q    <= '0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_valid_q   <= pend_valid_d;
      pend_pc_q      <= pend_pc_d;
      imem_req_q     <= imem_req_d;
      inst_valid_q   <= inst_valid_d;
      inst_pc_q      <= inst_pc_d;
      inst_data_q    <= inst_data_d;
      fetch_err_q    <= fetch_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        fetch_err;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .fetch_err      (fetch_err),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect an outstanding request at addr, answer it at once, expect it held.
  task automatic accept(input logic [31:0] addr, input logic [31:0] data);
    check("acc_req", {31'd0, imem_req}, 32'd1);
    check("acc_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    check("acc_valid", {31'd0, inst_valid}, 32'd1);
    check("acc_pc", inst_pc, addr);
    check("acc_data", inst_data, data);
    check("acc_req_off", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // Release with a stale ack present: must not be taken as reset-fetch data.
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    check("rel_req_pre", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'd0);
    check("rel_valid", {31'd0, inst_valid}, 32'd0);

    // Zero-wait streaming with decode always ready: 0, 4, 8.
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      accept(32'(4 * k), 32'hA000_0000 + 32'(k));
      tick();
      check("seq_req", {31'd0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, 32'(4 * (k + 1)));
      check("seq_valid", {31'd0, inst_valid}, 32'd0);
    end
    inst_ready = 1'b0;

    // Redirect in HOLD together with inst_ready.
    accept(32'd12, 32'hC0DE_0001);
    inst_ready = 1'b1;
    redirect(32'h100);
    inst_ready = 1'b0;
    check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("hold_redir_req", {31'd0, imem_req}, 32'd1);
    check("hold_redir_addr", imem_addr, 32'h100);
    tick();
    check("hold_redir_norepr", {31'd0, inst_valid}, 32'd0);

    // Two redirects while the ack is delayed; latest target wins.
    redirect(32'h200);
    check("pend1_addr", imem_addr, 32'h100);
    redirect(32'h300);
    check("pend2_addr", imem_addr, 32'h100);
    tick();
    tick();
    check("pend_wait_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("pend_discard_valid", {31'd0, inst_valid}, 32'd0);
    check("pend_refetch_req", {31'd0, imem_req}, 32'd1);
    check("pend_refetch_addr", imem_addr, 32'h300);

    // Address wrap at the top of the address space.
    accept(32'h300, 32'h1111_1111);
    redirect(32'hFFFF_FFFC);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    accept(32'hFFFF_FFFC, 32'h2222_2222);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Misaligned redirect target.
    accept(32'h0, 32'h3333_3333);
    redirect(32'h102);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_flag", {31'd0, misalign_err}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
`else
    check("mis_err", {31'd0, fetch_err}, 32'd0);
    check("mis_flag", {31'd0, misalign_err}, 32'd0);
    check("mis_req", {31'd0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
`endif

    // Asynchronous reset pulse mid-operation.
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_err", {31'd0, fetch_err}, 32'd0);
    check("arst_inst_pc", inst_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("to_start_req", {31'd0, imem_req}, 32'd1);
    check("to_start_addr", imem_addr, 32'd0);

    // Timeout: 15 request cycles without ack halt the controller.
    repeat (14) tick();
    check("to_14_err", {31'd0, fetch_err}, 32'd0);
    check("to_14_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("to_15_err", {31'd0, fetch_err}, 32'd1);
    check("to_15_req", {31'd0, imem_req}, 32'd0);
    check("to_15_valid", {31'd0, inst_valid}, 32'd0);

    // ERR ignores all inputs.
    imem_ack       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    repeat (3) tick();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    check("err_hold_req", {31'd0, imem_req}, 32'd0);
    check("err_hold_err", {31'd0, fetch_err}, 32'd1);
    check("err_hold_valid", {31'd0, inst_valid}, 32'd0);

    // Only reset leaves ERR.
    rst_n = 1'b0;
    #1;
    check("err_rst_err", {31'd0, fetch_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("err_rst_req", {31'd0, imem_req}, 32'd1);
    check("err_rst_addr", imem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 15: cycles a request may wait for ack before timeout; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 redirect_valid  input  1  jal/jalr/taken-branch redirect, one-cycle pulse.
REQ-006 redirect_pc  input  32  redirect target, valid with redirect_valid.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  fetch address, stable while imem_req=1.
REQ-009 imem_ack  input  1  memory response strobe; may coincide with the first imem_req cycle.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 inst_valid  output  1  held instruction available to decode.
REQ-012 inst_ready  input  1  decode accepts the held instruction.
REQ-013 inst_pc  output  32  address of the held instruction.
REQ-014 inst_data  output  32  held instruction word.
REQ-015 fetch_err  output  1  sticky error: timeout or misaligned redirect.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 FSM states: FETCH (req outstanding), HOLD (instruction held), ERR (halted).
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack with no pending redirect, next cycle HOLD with inst_valid=1, inst_pc=pc, inst_data=imem_rdata.
REQ-019 HOLD: imem_req=0; inst_valid, inst_pc, inst_data stable until inst_ready=1; then next cycle FETCH at pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
REQ-020 Redirect in HOLD: held instruction dropped, inst_valid=0 next cycle, FETCH at redirect_pc; redirect wins over simultaneous inst_ready.
REQ-021 Redirect in FETCH before ack: imem_addr unchanged; target latched as pending; a later redirect overwrites it (latest wins).
REQ-022 Ack with pending or same-cycle redirect: rdata discarded, inst_valid stays 0, next cycle FETCH at that target (same-cycle redirect takes priority over pending).
REQ-023 Wait counter clears on entry to FETCH and increments each FETCH cycle without ack; reaching MAX_WAIT with no ack -> ERR next cycle.
REQ-024 ERR: imem_req=0, inst_valid=0, fetch_err=1; inputs ignored; exit only via reset.
REQ-025 Minimum throughput with zero-wait memory: one instruction per two cycles.

Reset
REQ-026 While rst_n=0: FETCH state, pc=RESET_PC, imem_req=0, inst_valid=0, inst_pc=0, inst_data=0, fetch_err=0, misalign_err=0, pending cleared, counter 0.
REQ-027 First cycle after rst_n deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-028 Reset mid-request discards the outstanding request; a late ack after reset is not accepted as the reset fetch's data unless imem_req=1 that cycle.

Configuration
REQ-029 Macro FETCH_CTRL_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> ERR next cycle with fetch_err=1 and misalign_err=1.
REQ-030 Macro undefined: redirect_pc[1:0] forced to 2'b00 before use; misalign_err tied 0.

Structure
REQ-031 Package fetch_pkg holds the fetch_state_t enum (FETCH, HOLD, ERR) and constant INSN_BYTES=4.
REQ-032 Sub-module fetch_wait_ctr implements the MAX_WAIT counter (clear, enable, expired output).

Verification
REQ-033 Reset release, ack on first req cycle, inst_ready held 1 -> addresses 0,4,8 with inst_valid every 2nd cycle.
REQ-034 In HOLD, redirect_valid=1 with redirect_pc=32'h100 and inst_ready=1 same cycle -> next imem_addr=32'h100, held instruction not re-presented.
REQ-035 Redirect to 32'h200 then 32'h300 while ack delayed 5 cycles -> ack data discarded, next fetch at 32'h300.
REQ-036 No ack for MAX_WAIT=15 cycles -> fetch_err=1, imem_req=0 until rst_n pulsed.
REQ-037 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-038 redirect_pc=32'h102: with macro -> misalign_err=1, ERR; without -> fetch at 32'h100.
